io_intr_timer: RTL and testbench

//  Memory-mapped IO peripheral on the CPU io_cs/io_rd/io_wr bus; responder side of the CPU intr/int_ack handshake.

---
 rtl/io_intr_timer_pkg.sv | 29 ++
 rtl/io_down_counter.sv | 51 +++++
 rtl/io_intr_timer.sv | 139 +++++++++++++
 tb/tb_io_intr_timer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/io_intr_timer_pkg.sv
// Shared definitions for the IO interrupt timer: register map, CTRL/STATUS layouts and
// handshake FSM encoding.
package io_intr_timer_pkg;

  // Word-offset register indices, taken from addr[4:2].
  localparam logic [2:0] RegCtrl   = 3'd0;
  localparam logic [2:0] RegLoad   = 3'd1;
  localparam logic [2:0] RegCount  = 3'd2;
  localparam logic [2:0] RegStatus = 3'd3;
  localparam logic [2:0] RegSwint  = 3'd4;

  typedef struct packed {
    logic ie;
    logic reload;
    logic en;
  } ctrl_t;

  typedef struct packed {
    logic ovf;
    logic pend;
  } status_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StSvc  = 2'd2
  } hs_state_e;

endpackage

// File: rtl/io_down_counter.sv
// Loadable down-counter with optional auto-reload; flags the 1->0 transition as a terminal count.
module io_down_counter #(
  parameter int unsigned CntW = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [CntW-1:0] load_val_i,
  input  logic            start_i,
  input  logic            en_i,
  input  logic            reload_i,
  output logic [CntW-1:0] count_o,
  output logic            tc_o,
  output logic            stop_o
);

  localparam logic [CntW-1:0] One = CntW'(1);

  logic [CntW-1:0] count_q, count_d;
  logic            tc;

  always_comb begin
    count_d = count_q;
    tc      = 1'b0;
    if (start_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      if (count_q == One) begin
        count_d = '0;
        tc      = 1'b1;
      end else if (count_q != '0) begin
        count_d = count_q - One;
      end else if (reload_i) begin
        // Sits at zero for one cycle after the event, then reloads.
        count_d = load_val_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = tc;
  assign stop_o  = tc & ~reload_i;

endmodule

// File: rtl/io_intr_timer.sv
// Memory-mapped timer/software-interrupt peripheral with a registered intr/int_ack handshake
// and a tri-stated read port shared with data memory.
module io_intr_timer
  import io_intr_timer_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic              cs,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] io_in,
  output logic [DATA_W-1:0] io_out,
  output logic              int_r,
  input  logic              int_ack
);

  ctrl_t             ctrl_q, ctrl_d;
  logic [DATA_W-1:0] load_q, load_d;
  status_t           status_q, status_d;
  hs_state_e         state_q, state_d;
  logic              int_r_q;
  logic              start_q, start_d;

  logic [2:0]        reg_idx;
  logic              wr_en, rd_en;
  logic              sw_set, ack_clr;
  logic [1:0]        w1c;
  logic [CNT_W-1:0]  count;
  logic              tc, stop;
  logic [DATA_W-1:0] rdata;
  logic              unused_addr;

  assign reg_idx     = addr[4:2];
  assign wr_en       = cs & wr;
  assign rd_en       = cs & rd;
  assign unused_addr = ^{addr[ADDR_W-1:5], addr[1:0]};

  assign sw_set = wr_en && (reg_idx == RegSwint) && io_in[0];
  assign w1c    = (wr_en && (reg_idx == RegStatus)) ? io_in[1:0] : 2'b00;

  always_comb begin
    ctrl_d  = ctrl_q;
    load_d  = load_q;
    start_d = 1'b0;
    if (wr_en && (reg_idx == RegCtrl)) begin
      ctrl_d  = ctrl_t'(io_in[2:0]);
      start_d = io_in[0] & ~ctrl_q.en;
    end else if (stop) begin
      ctrl_d.en = 1'b0;
    end
    if (wr_en && (reg_idx == RegLoad)) begin
      load_d = io_in;
    end
  end

  io_down_counter #(
    .CntW (CNT_W)
  ) u_counter (
    .clk_i      (sys_clk),
    .rst_ni     (reset_n),
    .load_val_i (load_q[CNT_W-1:0]),
    .start_i    (start_q),
    .en_i       (ctrl_q.en),
    .reload_i   (ctrl_q.reload),
    .count_o    (count),
    .tc_o       (tc),
    .stop_o     (stop)
  );

  // Handshake FSM; int_r is the registered decode of the next state.
  always_comb begin
    state_d = state_q;
    ack_clr = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (status_q.pend && ctrl_q.ie) state_d = StReq;
      end
      StReq: begin
        if (int_ack) begin
          state_d = StSvc;
          ack_clr = 1'b1;
        end else if (!(status_q.pend && ctrl_q.ie)) begin
          state_d = StIdle;
        end
      end
      StSvc: begin
        if (!int_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Set sources win over clears so a coincident event is never lost.
  always_comb begin
    status_d = status_q;
    if (w1c[0] || ack_clr) status_d.pend = 1'b0;
    if (tc || sw_set)      status_d.pend = 1'b1;
    if (w1c[1])            status_d.ovf  = 1'b0;
    if (tc && status_q.pend) status_d.ovf = 1'b1;
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q   <= '0;
      load_q   <= '0;
      status_q <= '0;
      state_q  <= StIdle;
      int_r_q  <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      load_q   <= load_d;
      status_q <= status_d;
      state_q  <= state_d;
      int_r_q  <= (state_d == StReq);
      start_q  <= start_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_idx)
      RegCtrl:   rdata[2:0]       = ctrl_q;
      RegLoad:   rdata            = load_q;
      RegCount:  rdata[CNT_W-1:0] = count;
      RegStatus: rdata[1:0]       = status_q;
      default:   rdata            = '0;
    endcase
  end

  assign io_out = rd_en ? rdata : 'z;
  assign int_r  = int_r_q;

endmodule

// File: tb/tb_io_intr_timer.sv
// Directed bench for io_intr_timer with a data-memory driver sharing the read bus.
module tb_io_intr_timer;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;

  localparam logic [AW-1:0] ACtrl   = 12'h000;
  localparam logic [AW-1:0] ALoad   = 12'h004;
  localparam logic [AW-1:0] ACount  = 12'h008;
  localparam logic [AW-1:0] AStatus = 12'h00C;
  localparam logic [AW-1:0] ASwint  = 12'h010;
  localparam logic [AW-1:0] AUnmap  = 12'h01C;
  localparam logic [DW-1:0] DmWord  = 32'hA5A5_0F0F;

  logic          sys_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cs = 1'b0, rd = 1'b0, wr = 1'b0, int_ack = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] io_in = '0;
  logic          dm_oe = 1'b0;
  wire  [DW-1:0] rd_bus;
  wire           int_r;

  int total = 0;
  int bad   = 0;

  assign rd_bus = dm_oe ? DmWord : 'z;

  always #5 sys_clk = ~sys_clk;

  io_intr_timer #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .CNT_W  (32)
  ) dut (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .cs      (cs),
    .rd      (rd),
    .wr      (wr),
    .addr    (addr),
    .io_in   (io_in),
    .io_out  (rd_bus),
    .int_r   (int_r),
    .int_ack (int_ack)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic wr_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; io_in = d;
    @(negedge sys_clk);
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    logic [DW-1:0] d;
    cs = 1'b1; rd = 1'b1; addr = a;
    #1 d = rd_bus;
    cs = 1'b0; rd = 1'b0;
    #1 chk(tag, d, exp);
  endtask

  task automatic chk_int(input string tag, input logic exp);
    chk(tag, DW'(int_r), DW'(exp));
  endtask

  initial begin
    step(2);
    reset_n = 1'b1;
    step(1);

    // 1: reset in the middle of a countdown
    wr_reg(ALoad, 32'd10);
    wr_reg(ACtrl, 32'h1);
    chk_reg("cnt_before_load", ACount, 32'd0);
    step(6);
    chk_reg("cnt_mid", ACount, 32'd5);
    reset_n = 1'b0;
    #1 chk_int("rst_int_r", 1'b0);
    chk_reg("rst_count", ACount, 32'd0);
    chk_reg("rst_ctrl", ACtrl, 32'd0);
    dm_oe = 1'b1;
    #1 chk("rst_bus_dm", rd_bus, DmWord);
    dm_oe = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(1);

    // 2: one-shot countdown with interrupt and single-cycle ack
    wr_reg(ALoad, 32'd3);
    wr_reg(ACtrl, 32'h5);
    chk_reg("os_cnt_start", ACount, 32'd0);
    step(1); chk_reg("os_cnt3", ACount, 32'd3);
    step(1); chk_reg("os_cnt2", ACount, 32'd2);
    step(1); chk_reg("os_cnt1", ACount, 32'd1);
    chk_reg("os_stat_pre", AStatus, 32'd0);
    step(1); chk_reg("os_cnt0", ACount, 32'd0);
    chk_reg("os_stat_pend", AStatus, 32'd1);
    chk_int("os_int_lag", 1'b0);
    chk_reg("os_en_clr", ACtrl, 32'h4);
    step(1); chk_int("os_int_up", 1'b1);
    int_ack = 1'b1; step(1); int_ack = 1'b0;
    chk_int("os_int_ack", 1'b0);
    chk_reg("os_stat_ack", AStatus, 32'd0);
    step(1); chk_int("os_int_idle", 1'b0);

    // 3: auto-reload, overflow and W1C
    wr_reg(ALoad, 32'd4);
    wr_reg(ACtrl, 32'h7);
    step(5);
    chk_reg("ar_cnt_ev1", ACount, 32'd0);
    chk_reg("ar_stat_ev1", AStatus, 32'd1);
    step(1);
    chk_reg("ar_reload", ACount, 32'd4);
    chk_int("ar_int_up", 1'b1);
    step(4);
    chk_reg("ar_stat_ovf", AStatus, 32'd3);
    chk_int("ar_int_held", 1'b1);
    wr_reg(AStatus, 32'h3);
    chk_reg("ar_w1c", AStatus, 32'd0);
    step(3);
    chk_reg("ar_cnt_pre_ev", ACount, 32'd1);
    wr_reg(AStatus, 32'h3);
    chk_reg("ar_w1c_vs_ev", AStatus, 32'd1);
    wr_reg(ACtrl, 32'h0);
    wr_reg(AStatus, 32'h3);
    chk_int("ar_int_off", 1'b0);
    chk_reg("ar_stat_clean", AStatus, 32'd0);

    // 4: software interrupt with multi-cycle ack and a request during service
    wr_reg(ACtrl, 32'h4);
    wr_reg(ASwint, 32'h1);
    chk_reg("sw_pend", AStatus, 32'd1);
    chk_int("sw_int_lag", 1'b0);
    step(1); chk_int("sw_int_up", 1'b1);
    int_ack = 1'b1;
    step(1); chk_int("svc_c1", 1'b0);
    chk_reg("svc_pend_clr", AStatus, 32'd0);
    wr_reg(ASwint, 32'h1);
    chk_int("svc_c2", 1'b0);
    chk_reg("svc_pend_new", AStatus, 32'd1);
    step(1); chk_int("svc_c3", 1'b0);
    int_ack = 1'b0;
    step(1); chk_int("svc_gap", 1'b0);
    step(1); chk_int("svc_rereq", 1'b1);
    int_ack = 1'b1; step(1); int_ack = 1'b0;
    chk_reg("svc_done", AStatus, 32'd0);
    step(1);

    // 5: bus behaviour
    wr_reg(ACount, 32'hDEAD);
    chk_reg("bus_cnt_ro", ACount, 32'd4);
    chk_reg("bus_unmap", AUnmap, 32'd0);
    chk_reg("bus_swint_wo", ASwint, 32'd0);
    chk_reg("bus_load", ALoad, 32'd4);
    chk_reg("bus_ctrl", ACtrl, 32'h4);
    dm_oe = 1'b1; rd = 1'b1; addr = ALoad;
    #1 chk("bus_dm_nocs", rd_bus, DmWord);
    cs = 1'b1; rd = 1'b0;
    #1 chk("bus_dm_nord", rd_bus, DmWord);
    cs = 1'b0; dm_oe = 1'b0;
    step(1);
    cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = ALoad; io_in = 32'h55;
    #1 chk("bus_rw_old", rd_bus, 32'd4);
    @(negedge sys_clk);
    #1 chk("bus_rw_new", rd_bus, 32'h55);
    cs = 1'b0; rd = 1'b0; wr = 1'b0;
    step(1);

    // 6: ie dropped while requesting
    wr_reg(ASwint, 32'h1);
    step(1); chk_int("ie_req", 1'b1);
    wr_reg(ACtrl, 32'h0);
    chk_int("ie_clr_lag", 1'b1);
    step(1); chk_int("ie_clr_drop", 1'b0);
    chk_reg("ie_pend_held", AStatus, 32'd1);
    int_ack = 1'b1; step(1); int_ack = 1'b0;
    chk_reg("ack_idle_ign", AStatus, 32'd1);
    chk_int("ack_idle_int", 1'b0);
    wr_reg(ACtrl, 32'h4);
    chk_int("ie_set_lag", 1'b0);
    step(1); chk_int("ie_set_req", 1'b1);

    // 7: reset in the middle of the handshake
    reset_n = 1'b0;
    #1 chk_int("hs_rst_int", 1'b0);
    step(1);
    reset_n = 1'b1;
    step(3);
    chk_int("hs_rst_after", 1'b0);
    chk_reg("hs_rst_stat", AStatus, 32'd0);
    chk_reg("hs_rst_ctrl", ACtrl, 32'd0);

    // 8: LOAD=0 with the timer enabled never fires
    wr_reg(ALoad, 32'd0);
    wr_reg(ACtrl, 32'h7);
    step(4);
    chk_reg("l0_cnt", ACount, 32'd0);
    chk_reg("l0_stat", AStatus, 32'd0);
    chk_int("l0_int", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
